// File: rtl/pwm_sequencer.sv
// Purpose: sequences the 3LFCC PWM stage through reset hold, soft-start, sync-aligned updates and fault safe state.
// Latency: all outputs are registered; duty and dead-time change one clk edge after the qualifying sync_evt.
// Backpressure: cmd_ready is low in FAULT, and in RUN while a shadow command waits for its sync_evt.
module pwm_sequencer #(
    parameter logic [6:0] D_MAX      = 7'd100,
    parameter logic [6:0] RAMP_STEP  = 7'd1,
    parameter logic [4:0] DT_DEFAULT = 5'd2,
    parameter logic [4:0] DT_MIN     = 5'd1
) (
    input  logic       clk,
    input  logic       RST_n,
    input  logic       enable,
    input  logic       fault,
    input  logic       sync_evt,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic [6:0] cmd_d1,
    input  logic [6:0] cmd_d2,
    input  logic [4:0] cmd_dt,
    output logic [6:0] d1,
    output logic [6:0] d2,
    output logic [4:0] dt,
    output logic       pwm_rst,
    output logic [2:0] state,
    output logic       fault_latched
);
    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        ARM   = 3'd1,
        RAMP  = 3'd2,
        RUN   = 3'd3,
        FAULT = 3'd4
    } state_t;

    state_t     st_q, st_d;
    logic [6:0] d1_q, d1_d, d2_q, d2_d;
    logic [6:0] tgt1_q, tgt1_d, tgt2_q, tgt2_d;
    logic [6:0] sh1_q, sh1_d, sh2_q, sh2_d;
    logic [4:0] dt_q, dt_d, tgt_dt_q, tgt_dt_d, sh_dt_q, sh_dt_d;
    logic       sh_vld_q, sh_vld_d, rdy_q, rdy_d, prst_q, prst_d, flt_q, flt_d;

    logic       cmd_acc;
    logic [6:0] sat1, sat2, eff1, eff2, ramp1, ramp2;
    logic [4:0] sat_dt, eff_dt;
    logic [7:0] sum1, sum2;

    assign cmd_acc = cmd_valid & rdy_q;
    assign sat1    = (cmd_d1 > D_MAX) ? D_MAX : cmd_d1;
    assign sat2    = (cmd_d2 > D_MAX) ? D_MAX : cmd_d2;
    assign sat_dt  = (cmd_dt < DT_MIN) ? DT_MIN : cmd_dt;

    // A command accepted on a ramp sync already steers that sync's step.
    assign eff1    = cmd_acc ? sat1 : tgt1_q;
    assign eff2    = cmd_acc ? sat2 : tgt2_q;
    assign eff_dt  = cmd_acc ? sat_dt : tgt_dt_q;

    assign sum1    = {1'b0, d1_q} + {1'b0, RAMP_STEP};
    assign sum2    = {1'b0, d2_q} + {1'b0, RAMP_STEP};
    assign ramp1   = (d1_q < eff1) ? ((sum1 > {1'b0, eff1}) ? eff1 : sum1[6:0]) : eff1;
    assign ramp2   = (d2_q < eff2) ? ((sum2 > {1'b0, eff2}) ? eff2 : sum2[6:0]) : eff2;

    always_ff @(posedge clk or negedge RST_n) begin
        if (!RST_n) begin
            st_q     <= IDLE;
            d1_q     <= '0;
            d2_q     <= '0;
            dt_q     <= DT_DEFAULT;
            tgt1_q   <= '0;
            tgt2_q   <= '0;
            tgt_dt_q <= DT_DEFAULT;
            sh1_q    <= '0;
            sh2_q    <= '0;
            sh_dt_q  <= DT_DEFAULT;
            sh_vld_q <= 1'b0;
            rdy_q    <= 1'b0;
            prst_q   <= 1'b1;
            flt_q    <= 1'b0;
        end else begin
            st_q     <= st_d;
            d1_q     <= d1_d;
            d2_q     <= d2_d;
            dt_q     <= dt_d;
            tgt1_q   <= tgt1_d;
            tgt2_q   <= tgt2_d;
            tgt_dt_q <= tgt_dt_d;
            sh1_q    <= sh1_d;
            sh2_q    <= sh2_d;
            sh_dt_q  <= sh_dt_d;
            sh_vld_q <= sh_vld_d;
            rdy_q    <= rdy_d;
            prst_q   <= prst_d;
            flt_q    <= flt_d;
        end
    end

    always_comb begin
        st_d     = st_q;
        d1_d     = d1_q;
        d2_d     = d2_q;
        dt_d     = dt_q;
        tgt1_d   = tgt1_q;
        tgt2_d   = tgt2_q;
        tgt_dt_d = tgt_dt_q;
        sh1_d    = sh1_q;
        sh2_d    = sh2_q;
        sh_dt_d  = sh_dt_q;
        sh_vld_d = sh_vld_q;
        flt_d    = flt_q;

        if (fault) begin
            st_d     = FAULT;
            d1_d     = '0;
            d2_d     = '0;
            sh_vld_d = 1'b0;
            flt_d    = 1'b1;
        end else if (!enable && st_q != IDLE && st_q != FAULT) begin
            st_d     = IDLE;
            d1_d     = '0;
            d2_d     = '0;
            sh_vld_d = 1'b0;
        end else begin
            case (st_q)
                IDLE, ARM, RAMP: begin
                    if (cmd_acc) begin
                        tgt1_d   = sat1;
                        tgt2_d   = sat2;
                        tgt_dt_d = sat_dt;
                    end
                    if (st_q == IDLE && enable) begin
                        st_d = ARM;
                    end else if (st_q == ARM && sync_evt) begin
                        st_d = RAMP;
                    end else if (st_q == RAMP && sync_evt) begin
                        d1_d = ramp1;
                        d2_d = ramp2;
                        dt_d = eff_dt;
                        if (ramp1 == eff1 && ramp2 == eff2) begin
                            st_d = RUN;
                        end
                    end
                end
                RUN: begin
                    // Targets follow applied values so a later re-enable ramps toward them.
                    if (sync_evt && sh_vld_q) begin
                        d1_d     = sh1_q;
                        d2_d     = sh2_q;
                        dt_d     = sh_dt_q;
                        tgt1_d   = sh1_q;
                        tgt2_d   = sh2_q;
                        tgt_dt_d = sh_dt_q;
                        sh_vld_d = 1'b0;
                    end
                    if (cmd_acc) begin
                        sh1_d    = sat1;
                        sh2_d    = sat2;
                        sh_dt_d  = sat_dt;
                        sh_vld_d = 1'b1;
                    end
                end
                FAULT: begin
                    if (!enable) begin
                        st_d  = IDLE;
                        flt_d = 1'b0;
                    end
                end
                default: begin
                    st_d = IDLE;
                    d1_d = '0;
                    d2_d = '0;
                end
            endcase
        end

        prst_d = (st_d == IDLE) || (st_d == FAULT);
        rdy_d  = (st_d == FAULT) ? 1'b0 : (st_d == RUN) ? !sh_vld_d : 1'b1;
    end

    assign cmd_ready     = rdy_q;
    assign d1            = d1_q;
    assign d2            = d2_q;
    assign dt            = dt_q;
    assign pwm_rst       = prst_q;
    assign state         = st_q;
    assign fault_latched = flt_q;
endmodule

// File: tb/tb_pwm_sequencer.sv
// Directed bench for pwm_sequencer: soft-start, RUN shadow table, saturation, fault and async reset.
module tb_pwm_sequencer;
    logic       clk = 1'b0;
    logic       RST_n = 1'b0;
    logic       enable = 1'b0;
    logic       fault = 1'b0;
    logic       sync_evt = 1'b0;
    logic       cmd_valid = 1'b0;
    logic [6:0] cmd_d1 = '0;
    logic [6:0] cmd_d2 = '0;
    logic [4:0] cmd_dt = '0;
    logic       cmd_ready, pwm_rst, fault_latched;
    logic [6:0] d1, d2;
    logic [4:0] dt;
    logic [2:0] state;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic       en, flt, sy, cv;
        logic [6:0] c1, c2;
        logic [4:0] cdt;
        int         st, e1, e2, edt, rdy, pr;
    } vec_t;

    vec_t tbl [13];

    pwm_sequencer dut (
        .clk(clk), .RST_n(RST_n), .enable(enable), .fault(fault), .sync_evt(sync_evt),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_d1(cmd_d1), .cmd_d2(cmd_d2),
        .cmd_dt(cmd_dt), .d1(d1), .d2(d2), .dt(dt), .pwm_rst(pwm_rst), .state(state),
        .fault_latched(fault_latched)
    );

    always #5 clk = ~clk;

    function automatic vec_t mk(input int en, input int sy, input int cv, input int c1, input int c2,
                                input int cdt, input int st, input int e1, input int e2,
                                input int edt, input int rdy, input int pr);
        vec_t v;
        v.en = 1'(en); v.flt = 1'b0; v.sy = 1'(sy); v.cv = 1'(cv);
        v.c1 = 7'(c1); v.c2 = 7'(c2); v.cdt = 5'(cdt);
        v.st = st; v.e1 = e1; v.e2 = e2; v.edt = edt; v.rdy = rdy; v.pr = pr;
        return v;
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic chk_all(input string tag, input int st, input int e1, input int e2, input int edt,
                           input int rdy, input int pr, input int fl);
        chk({tag, "_state"}, int'(state), st);
        chk({tag, "_d1"}, int'(d1), e1);
        chk({tag, "_d2"}, int'(d2), e2);
        chk({tag, "_dt"}, int'(dt), edt);
        chk({tag, "_cmd_ready"}, int'(cmd_ready), rdy);
        chk({tag, "_pwm_rst"}, int'(pwm_rst), pr);
        chk({tag, "_fault_latched"}, int'(fault_latched), fl);
    endtask

    // Drive one cycle of inputs at negedge, then sample 1 time unit after the posedge.
    task automatic step(input logic en, input logic flt, input logic sy, input logic cv,
                        input logic [6:0] c1, input logic [6:0] c2, input logic [4:0] cdt);
        @(negedge clk);
        enable = en; fault = flt; sync_evt = sy; cmd_valid = cv;
        cmd_d1 = c1; cmd_d2 = c2; cmd_dt = cdt;
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_sync(input int gap, input logic en);
        for (int g = 0; g < gap; g++) step(en, 1'b0, 1'b0, 1'b0, 7'd0, 7'd0, 5'd0);
        step(en, 1'b0, 1'b1, 1'b0, 7'd0, 7'd0, 5'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout actual running expected finished");
        $fatal(1, "watchdog");
    end

    initial begin
        int e1, e2, est;

        // In RUN at d=40/60/dt3: shadow, simultaneous accept+sync, saturation, busy shadow, disable.
        tbl[0]  = mk(1, 0, 1,  50,  50, 2, 3,  40,  60, 3, 0, 0);
        tbl[1]  = mk(1, 0, 0,   0,   0, 0, 3,  40,  60, 3, 0, 0);
        tbl[2]  = mk(1, 1, 0,   0,   0, 0, 3,  50,  50, 2, 1, 0);
        tbl[3]  = mk(1, 1, 1,  30,  20, 4, 3,  50,  50, 2, 0, 0);
        tbl[4]  = mk(1, 0, 0,   0,   0, 0, 3,  50,  50, 2, 0, 0);
        tbl[5]  = mk(1, 1, 0,   0,   0, 0, 3,  30,  20, 4, 1, 0);
        tbl[6]  = mk(1, 0, 1, 120, 127, 0, 3,  30,  20, 4, 0, 0);
        tbl[7]  = mk(1, 1, 0,   0,   0, 0, 3, 100, 100, 1, 1, 0);
        tbl[8]  = mk(1, 1, 0,   0,   0, 0, 3, 100, 100, 1, 1, 0);
        tbl[9]  = mk(1, 0, 1,  10,  10, 5, 3, 100, 100, 1, 0, 0);
        tbl[10] = mk(1, 0, 1,  90,  90, 9, 3, 100, 100, 1, 0, 0);
        tbl[11] = mk(1, 1, 0,   0,   0, 0, 3,  10,  10, 5, 1, 0);
        tbl[12] = mk(0, 0, 0,   0,   0, 0, 0,   0,   0, 5, 1, 1);

        // Reset values while RST_n is held low.
        #12;
        chk_all("reset", 0, 0, 0, 2, 0, 1, 0);
        @(negedge clk);
        RST_n = 1'b1;
        @(posedge clk);
        #1;
        chk("idle_ready", int'(cmd_ready), 1);

        // Soft-start toward 40/60, dt 3.
        step(1'b0, 1'b0, 1'b0, 1'b1, 7'd40, 7'd60, 5'd3);
        chk_all("idle_cmd", 0, 0, 0, 2, 1, 1, 0);
        step(1'b1, 1'b0, 1'b0, 1'b0, 7'd0, 7'd0, 5'd0);
        chk_all("arm", 1, 0, 0, 2, 1, 0, 0);
        for (int k = 1; k <= 61; k++) begin
            pulse_sync(9, 1'b1);
            e1  = (k - 1 > 40) ? 40 : k - 1;
            e2  = k - 1;
            est = (k == 61) ? 3 : 2;
            chk($sformatf("ramp%0d_d1", k), int'(d1), e1);
            chk($sformatf("ramp%0d_d2", k), int'(d2), e2);
            chk($sformatf("ramp%0d_state", k), int'(state), est);
            chk($sformatf("ramp%0d_dt", k), int'(dt), (k == 1) ? 2 : 3);
        end
        chk_all("run_entry", 3, 40, 60, 3, 1, 0, 0);

        for (int i = 0; i < 13; i++) begin
            step(tbl[i].en, tbl[i].flt, tbl[i].sy, tbl[i].cv, tbl[i].c1, tbl[i].c2, tbl[i].cdt);
            chk($sformatf("row%0d_state", i), int'(state), tbl[i].st);
            chk($sformatf("row%0d_d1", i), int'(d1), tbl[i].e1);
            chk($sformatf("row%0d_d2", i), int'(d2), tbl[i].e2);
            chk($sformatf("row%0d_dt", i), int'(dt), tbl[i].edt);
            chk($sformatf("row%0d_ready", i), int'(cmd_ready), tbl[i].rdy);
            chk($sformatf("row%0d_pwm_rst", i), int'(pwm_rst), tbl[i].pr);
        end

        // Fault in the middle of a ramp at d1=17.
        step(1'b0, 1'b0, 1'b0, 1'b1, 7'd40, 7'd60, 5'd3);
        step(1'b1, 1'b0, 1'b0, 1'b0, 7'd0, 7'd0, 5'd0);
        chk("fault_arm_state", int'(state), 1);
        for (int k = 0; k < 18; k++) pulse_sync(2, 1'b1);
        chk_all("pre_fault", 2, 17, 17, 3, 1, 0, 0);
        step(1'b1, 1'b1, 1'b0, 1'b0, 7'd0, 7'd0, 5'd0);
        chk_all("fault_entry", 4, 0, 0, 3, 0, 1, 1);
        for (int k = 0; k < 3; k++) begin
            step(1'b1, 1'b0, 1'b0, 1'b0, 7'd0, 7'd0, 5'd0);
            chk_all($sformatf("fault_hold%0d", k), 4, 0, 0, 3, 0, 1, 1);
        end
        step(1'b0, 1'b0, 1'b0, 1'b0, 7'd0, 7'd0, 5'd0);
        chk_all("fault_exit", 0, 0, 0, 3, 1, 1, 0);

        // Reach RUN quickly, then assert async reset between clock edges.
        step(1'b0, 1'b0, 1'b0, 1'b1, 7'd2, 7'd1, 5'd3);
        step(1'b1, 1'b0, 1'b0, 1'b0, 7'd0, 7'd0, 5'd0);
        pulse_sync(1, 1'b1);
        pulse_sync(1, 1'b1);
        chk_all("short_ramp", 2, 1, 1, 3, 1, 0, 0);
        pulse_sync(1, 1'b1);
        chk_all("short_run", 3, 2, 1, 3, 1, 0, 0);
        @(posedge clk);
        #3;
        RST_n = 1'b0;
        #1;
        chk_all("async_reset", 0, 0, 0, 2, 0, 1, 0);
        @(negedge clk);
        RST_n = 1'b1;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/pwm_sequencer.md
Name: pwm_sequencer

Overview:
Controller for the phase-shifted PWM stage of the 3LFCC. It holds the PWM stage in reset until it is enabled, then soft-starts both duty cycles d1 and d2 from 0 toward commanded targets. Once running, it applies new duty and dead-time commands only at carrier sync events, so the triangular comparison never sees a mid-period change. A fault input forces the power stage into its safe state: all switches off, which is the PWM stage's own reset state.

Parameters:
D_MAX, 7'd100, upper saturation limit for d1/d2 (the carrier peak)
RAMP_STEP, 7'd1, duty increment per sync event during soft-start
DT_DEFAULT, 5'd2, dead-time value after reset
DT_MIN, 5'd1, lower clamp for the commanded dead-time

Ports:
clk  in  1  main clock, same domain as the PWM stage
RST_n  in  1  asynchronous active-low reset
enable  in  1  level; 1 = run converter, 0 = stop
fault  in  1  level; 1 = hardware fault (overcurrent, overvoltage)
sync_evt  in  1  one-cycle pulse at the carrier valley, driven from the PWM stage's XADC_Event
cmd_valid  in  1  command valid
cmd_ready  out  1  command accepted when cmd_valid & cmd_ready on a clk edge
cmd_d1  in  7  target duty for channel 1
cmd_d2  in  7  target duty for channel 2
cmd_dt  in  5  target dead-time
d1  out  7  duty to PWM stage
d2  out  7  duty to PWM stage
dt  out  5  dead-time to PWM stage
pwm_rst  out  1  active-high reset to PWM stage; forces all switches off
state  out  3  FSM state code: IDLE=0, ARM=1, RAMP=2, RUN=3, FAULT=4
fault_latched  out  1  set on fault entry; cleared on the FAULT->IDLE transition

Behaviour:
- Reset (async, RST_n=0):
  - state=IDLE, d1=d2=0, dt=DT_DEFAULT, pwm_rst=1, cmd_ready=0, fault_latched=0.
  - Targets tgt1=tgt2=0, tgt_dt=DT_DEFAULT, shadow empty.
- All outputs are registered.
- Priority each cycle: fault > !enable > sync/command activity.
- IDLE:
  - pwm_rst=1, d1=d2=0, cmd_ready=1; accepted commands load the targets.
  - enable=1 & fault=0 -> ARM.
- ARM:
  - pwm_rst=0, d1=d2=0, cmd_ready=1.
  - First sync_evt -> RAMP. No duty change occurs on that event.
- RAMP:
  - cmd_ready=1; an accepted command writes the targets directly.
  - On each sync_evt, per channel independently:
    - if d < tgt, then d = min(d + RAMP_STEP, tgt), computed 8 bits wide so there is no wrap;
    - otherwise d = tgt.
  - dt = tgt_dt on each sync_evt.
  - When both channels equal their targets after an update -> RUN in the same cycle.
- RUN:
  - cmd_ready = shadow empty.
  - An accepted command goes into the shadow. cmd_ready=0 while the shadow is pending.
  - On sync_evt with the shadow pending: d1, d2 and dt take the shadow values, and the shadow empties (cmd_ready=1 the next cycle).
  - A command accepted in the same cycle as sync_evt is applied at the following sync_evt, not the current one.
- Saturation on capture, in every state:
  - cmd_d > D_MAX -> D_MAX.
  - cmd_dt < DT_MIN -> DT_MIN.
- enable=0 in ARM/RAMP/RUN -> IDLE on the next edge:
  - d1=d2=0, pwm_rst=1;
  - shadow cleared; targets retained.
- fault=1 in any state -> FAULT on the next edge:
  - d1=d2=0, pwm_rst=1, fault_latched=1, cmd_ready=0;
  - shadow cleared.
- FAULT: leave only when fault=0 & enable=0 -> IDLE. fault_latched clears on that transition.
- sync_evt held high for multiple cycles counts once per cycle. The source guarantees single-cycle pulses; the bench checks that case only.
- d1 and d2 never change except on sync_evt, entry to IDLE/FAULT, or reset.

Test Plan:
- Soft-start: after reset, send cmd 40/60/dt 3 in IDLE, set enable=1, sync every 10 clks -> ARM on the first sync; d1 reaches 40 after 41 syncs, d2 reaches 60 after 61 syncs; state=RUN when d2=60; dt=3 from the first ramp sync.
- Shadow update in RUN: cmd 50/50/2 -> cmd_ready drops the next cycle; d unchanged until sync_evt; then d1=d2=50, dt=2 and cmd_ready=1.
- Simultaneous cmd accept and sync_evt in RUN -> outputs unchanged on that sync; new values appear on the next sync.
- Saturation: cmd 120/127/dt 0 -> target 100/100, dt=1.
- Fault mid-ramp at d1=17: fault=1 -> next edge d1=d2=0, pwm_rst=1, state=4, fault_latched=1. Dropping fault with enable=1 stays in FAULT; then enable=0 -> IDLE and fault_latched=0.
- Async reset asserted in RUN between clock edges -> outputs go to reset values immediately, without waiting for clk.
